acia_rx_fifo: RTL

Parametrised successor to the ACIA serial receiver, in the same UART path.
- Input sync and deglitch on the raw serial line.
- Runtime-programmable baud divisor, 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Received characters go into a small RX FIFO; each entry carries its own error tags, and overrun is a sticky flag.
- Sits between the pin and the ACIA register interface; the CPU pops one entry per data-register read.

---
 rtl/acia_pkg.sv | 31 +++
 rtl/acia_sync_fifo.sv | 47 ++++
 rtl/acia_rx_fifo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/acia_pkg.sv
// Shared types and constants for the ACIA receive path: parity codes, receiver
// FSM states and the per-character FIFO entry layout.
package acia_pkg;

  localparam int unsigned DATA_BITS_BASE = 5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  // Index of the final data bit for a data_bits code (5 + code bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
    return 3'(DATA_BITS_BASE - 1) + 3'(code);
  endfunction

endpackage

// File: rtl/acia_sync_fifo.sv
// First-word-fall-through FIFO; head shows combinationally, reads as zero when empty.
// A push into a full FIFO is dropped (o_drop) unless a pop frees the slot that cycle.
module acia_sync_fifo #(
  parameter int unsigned W  = 10,
  parameter int unsigned AW = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_drop
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_do_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/acia_rx_fifo.sv
// ACIA serial receiver: deglitched line, programmable framing, tagged RX FIFO.
// Define ACIA_RX_BREAK_EN to add break detection and the rx_brk output.
module acia_rx_fifo
  import acia_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned DG_LEN  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pclk,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  input  logic             rx_serial,
  input  logic             rd_stb,
  input  logic             err_clr,
  output logic [7:0]       rx_dat,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_avail,
  output logic             rx_full,
  output logic             rx_ovr
`ifdef ACIA_RX_BREAK_EN
  ,
  output logic             rx_brk
`endif
);

  logic [DG_LEN-1:0] r_dg;
  logic              r_line;
  rx_state_e         r_state;
  rx_state_e         w_next;
  logic [DIV_W-1:0]  r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_sh;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;
  logic [DIV_W-1:0]  w_div;
  logic              w_zero;
  logic              w_par_en;
  logic              w_last;
  logic              w_brk_hold;
  logic              w_push;
  rx_entry_t         w_push_ent;
  rx_entry_t         w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_drop;
`ifdef ACIA_RX_BREAK_EN
  logic              r_allz;
  logic              r_brk;
`endif

  assign w_div    = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign w_zero   = (r_cnt == '0);
  assign w_par_en = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
  assign w_last   = (r_bit == last_bit_idx(data_bits));

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (pclk) begin
      case (r_state)
        ST_IDLE:   if (!r_line && !w_brk_hold) w_next = ST_START;
        ST_START:  if (w_zero) w_next = r_line ? ST_IDLE : ST_DATA;
        ST_DATA:   if (w_zero && w_last) w_next = w_par_en ? ST_PARITY : ST_STOP1;
        ST_PARITY: if (w_zero) w_next = ST_STOP1;
        ST_STOP1:  if (w_zero) w_next = two_stop ? ST_STOP2 : ST_IDLE;
        ST_STOP2:  if (w_zero) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Push happens on the final stop sample; the stop sample itself feeds ferr directly.
  always_comb begin
    w_push          = 1'b0;
    w_push_ent      = '0;
    w_push_ent.data = r_sh;
    w_push_ent.perr = r_perr;
    w_push_ent.ferr = r_ferr | ~r_line;
    if (pclk && w_zero) begin
      case (r_state)
        ST_STOP1: w_push = ~two_stop;
        ST_STOP2: w_push = 1'b1;
        default:  w_push = 1'b0;
      endcase
    end
  end

  // Line state only flips once the whole deglitch window agrees.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dg   <= '1;
      r_line <= 1'b1;
    end else if (pclk) begin
      r_dg <= {r_dg[DG_LEN-2:0], rx_serial};
      if (&r_dg)       r_line <= 1'b1;
      else if (~|r_dg) r_line <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh   <= '0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (pclk) begin
      if (r_state == ST_IDLE) begin
        r_cnt  <= w_div >> 1;
        r_bit  <= '0;
        r_sh   <= '0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else if (w_zero) begin
        r_cnt <= w_div - DIV_W'(1);
        case (r_state)
          ST_DATA: begin
            r_sh[r_bit] <= r_line;
            r_bit       <= r_bit + 3'd1;
          end
          ST_PARITY: r_perr <= ((^r_sh) ^ r_line) != (parity_mode == PAR_ODD);
          ST_STOP1:  r_ferr <= r_ferr | ~r_line;
          default:   ;
        endcase
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

`ifdef ACIA_RX_BREAK_EN
  // Break: every sample after the start bit was 0; hold off restarts until line idles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_allz <= 1'b1;
      r_brk  <= 1'b0;
    end else if (pclk) begin
      if (r_state == ST_IDLE) r_allz <= 1'b1;
      else if (w_zero)        r_allz <= r_allz & ~r_line;
      if (w_push && r_allz && !r_line) r_brk <= 1'b1;
      else if (r_line)                 r_brk <= 1'b0;
    end
  end
  assign w_brk_hold = r_brk;
  assign rx_brk     = r_brk;
`else
  assign w_brk_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n)     r_ovr <= 1'b0;
    else if (w_drop)  r_ovr <= 1'b1;
    else if (err_clr) r_ovr <= 1'b0;
  end

  acia_sync_fifo #(
    .W  ($bits(rx_entry_t)),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_push_ent),
    .i_pop   (rd_stb),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign rx_dat   = w_head.data;
  assign rx_perr  = w_head.perr;
  assign rx_ferr  = w_head.ferr;
  assign rx_avail = ~w_empty;
  assign rx_full  = w_full;
  assign rx_ovr   = r_ovr;

endmodule
